btn_conditioner: RTL and testbench

//   Input conditioning stage for the button inputs of the Wishbone test peripheral. It feeds that peripheral's 2-bit `in` port.

---
 rtl/btn_cond_pkg.sv | 21 ++
 rtl/btn_conditioner_if.sv | 42 ++++
 rtl/btn_debounce_ch.sv | 68 ++++++
 rtl/btn_conditioner.sv | 68 ++++++
 tb/tb_btn_conditioner.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/btn_cond_pkg.sv
// ----------------------------------------------------------------------------
// btn_cond_pkg
//   Shared constants and types for the button conditioner.
//   BTN_COND_DEF_DEBOUNCE : default debounce length in clk cycles
//   BTN_COND_DEF_CNT_W    : default debounce counter width
//   BTN_COND_SYNC_STAGES  : flops in the pad synchroniser chain
//   btn_ch_out_t          : per-channel result (level + edge pulses)
// ----------------------------------------------------------------------------
package btn_cond_pkg;

    localparam int BTN_COND_DEF_DEBOUNCE = 16;
    localparam int BTN_COND_DEF_CNT_W    = 16;
    localparam int BTN_COND_SYNC_STAGES  = 2;

    typedef struct packed {
        logic level;
        logic rise;
        logic fall;
    } btn_ch_out_t;

endpackage

// File: rtl/btn_conditioner_if.sv
// ----------------------------------------------------------------------------
// btn_conditioner_if
//   Bundle between the button conditioner and its user.
//   btn_raw     : raw pad inputs (asynchronous)
//   evt_clr     : per-channel clear of evt_pending
//   btn_level   : debounced level
//   btn_rise    : 1-cycle pulse on debounced 0->1
//   btn_fall    : 1-cycle pulse on debounced 1->0
//   evt_pending : sticky per-channel change flag
//   irq_mask/irq: only present when BTN_COND_IRQ_EN is defined
//   master = user side, slave = conditioner side.
// ----------------------------------------------------------------------------
interface btn_conditioner_if #(
    parameter int N_BTN = 2
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] evt_clr;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_rise;
    logic [N_BTN-1:0] btn_fall;
    logic [N_BTN-1:0] evt_pending;
`ifdef BTN_COND_IRQ_EN
    logic [N_BTN-1:0] irq_mask;
    logic             irq;
`endif

    modport master (
        output btn_raw, output evt_clr,
`ifdef BTN_COND_IRQ_EN
        output irq_mask, input irq,
`endif
        input btn_level, input btn_rise, input btn_fall, input evt_pending
    );

    modport slave (
        input btn_raw, input evt_clr,
`ifdef BTN_COND_IRQ_EN
        input irq_mask, output irq,
`endif
        output btn_level, output btn_rise, output btn_fall, output evt_pending
    );
endinterface

// File: rtl/btn_debounce_ch.sv
// ----------------------------------------------------------------------------
// btn_debounce_ch
//   One button channel: pad synchroniser, debounce counter, edge pulses.
//   i_clk   : clock
//   i_rst_n : asynchronous active-low reset
//   i_raw   : raw pad bit
//   o_ch    : debounced level plus registered rise/fall pulses
//   The level only follows the synced input after it has differed from the
//   current level for DEBOUNCE_CYCLES consecutive cycles; any return to the
//   current level restarts the count.
// ----------------------------------------------------------------------------
module btn_debounce_ch
    import btn_cond_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = BTN_COND_DEF_DEBOUNCE,
    parameter int   CNT_W           = BTN_COND_DEF_CNT_W,
    parameter logic IDLE_BIT        = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_raw,
    output btn_ch_out_t o_ch
);
    localparam logic [CNT_W-1:0] LP_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [BTN_COND_SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]                r_cnt;
    logic                            r_level;
    logic                            r_rise;
    logic                            r_fall;

    logic w_sync;
    logic w_diff;
    logic w_accept;

    assign w_sync   = r_sync[BTN_COND_SYNC_STAGES-1];
    assign w_diff   = (w_sync != r_level);
    assign w_accept = w_diff && (r_cnt == LP_CNT_MAX);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync  <= {BTN_COND_SYNC_STAGES{IDLE_BIT}};
            r_cnt   <= '0;
            r_level <= IDLE_BIT;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync <= {r_sync[BTN_COND_SYNC_STAGES-2:0], i_raw};
            // Pulses are registered alongside the level update so they
            // coincide with the cycle the new level first appears.
            r_rise <= w_accept &  w_sync;
            r_fall <= w_accept & ~w_sync;
            if (!w_diff) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_level <= w_sync;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_ch.level = r_level;
    assign o_ch.rise  = r_rise;
    assign o_ch.fall  = r_fall;

endmodule

// File: rtl/btn_conditioner.sv
// ----------------------------------------------------------------------------
// btn_conditioner
//   Conditions N_BTN raw button pads for the Wishbone test peripheral.
//   clk     : single clock
//   reset_n : asynchronous active-low reset
//   bus     : btn_conditioner_if.slave (raw in, clears in, level/pulses/flags out)
//   Optional feature macro: BTN_COND_IRQ_EN adds bus.irq_mask and a registered
//   bus.irq = |(evt_pending & irq_mask).
//   One btn_debounce_ch per channel; this level owns evt_pending and irq.
// ----------------------------------------------------------------------------
module btn_conditioner
    import btn_cond_pkg::*;
#(
    parameter int               N_BTN           = 2,
    parameter int               DEBOUNCE_CYCLES = BTN_COND_DEF_DEBOUNCE,
    parameter int               CNT_W           = BTN_COND_DEF_CNT_W,
    parameter logic [N_BTN-1:0] IDLE_LEVEL      = {N_BTN{1'b1}}
) (
    input logic              clk,
    input logic              reset_n,
    btn_conditioner_if.slave bus
);
    btn_ch_out_t      w_ch [N_BTN];
    logic [N_BTN-1:0] w_level;
    logic [N_BTN-1:0] w_rise;
    logic [N_BTN-1:0] w_fall;
    logic [N_BTN-1:0] r_evt;

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W),
            .IDLE_BIT        (IDLE_LEVEL[g])
        ) u_ch (
            .i_clk   (clk),
            .i_rst_n (reset_n),
            .i_raw   (bus.btn_raw[g]),
            .o_ch    (w_ch[g])
        );
        assign w_level[g] = w_ch[g].level;
        assign w_rise[g]  = w_ch[g].rise;
        assign w_fall[g]  = w_ch[g].fall;
    end

    // Set has priority over clear so a change coinciding with a clear is
    // never lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_evt <= '0;
        else          r_evt <= (r_evt & ~bus.evt_clr) | w_rise | w_fall;
    end

    assign bus.btn_level   = w_level;
    assign bus.btn_rise    = w_rise;
    assign bus.btn_fall    = w_fall;
    assign bus.evt_pending = r_evt;

`ifdef BTN_COND_IRQ_EN
    logic r_irq;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_irq <= 1'b0;
        else          r_irq <= |(r_evt & bus.irq_mask);
    end

    assign bus.irq = r_irq;
`endif

endmodule

// File: tb/tb_btn_conditioner.sv
// ----------------------------------------------------------------------------
// tb_btn_conditioner
//   Directed bench for btn_conditioner with N_BTN=2, DEBOUNCE_CYCLES=4,
//   IDLE_LEVEL=2'b11. Inputs change on the falling edge; outputs are sampled
//   on the falling edge after each rising edge. The rising edge following a
//   change is the sampling edge; the level update lands on the 6th rising
//   edge counting that one (2 sync flops + 4 debounce cycles).
// ----------------------------------------------------------------------------
module tb_btn_conditioner;
    localparam int N   = 2;
    localparam int DEB = 4;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    btn_conditioner_if #(.N_BTN(N)) bus();

    btn_conditioner #(
        .N_BTN           (N),
        .DEBOUNCE_CYCLES (DEB),
        .CNT_W           (16),
        .IDLE_LEVEL      (2'b11)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        bus.btn_raw = 2'b11;
        bus.evt_clr = 2'b00;
`ifdef BTN_COND_IRQ_EN
        bus.irq_mask = 2'b01;
`endif
        tick(3);
        checks++;
        if ({bus.btn_level, bus.btn_rise, bus.btn_fall, bus.evt_pending} !== 8'b11_00_00_00) begin
            errors++;
            $display("FAIL reset_hold: got lvl/rise/fall/evt=%b expected 11000000",
                     {bus.btn_level, bus.btn_rise, bus.btn_fall, bus.evt_pending});
        end
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            checks++;
            if ({bus.btn_level, bus.btn_rise, bus.btn_fall, bus.evt_pending} !== 8'b11_00_00_00) begin
                errors++;
                $display("FAIL reset_idle cyc %0d: got %b expected 11000000", i,
                         {bus.btn_level, bus.btn_rise, bus.btn_fall, bus.evt_pending});
            end
        end
    endtask

    task automatic test_fall;
        bus.btn_raw = 2'b10;
        for (int k = 1; k <= 5; k++) begin
            tick(1);
            checks++;
            if ({bus.btn_level, bus.btn_fall} !== 4'b11_00) begin
                errors++;
                $display("FAIL fall_early edge %0d: got lvl/fall=%b expected 1100", k,
                         {bus.btn_level, bus.btn_fall});
            end
        end
        tick(1);
        checks++;
        if ({bus.btn_level, bus.btn_rise, bus.btn_fall, bus.evt_pending} !== 8'b10_00_01_00) begin
            errors++;
            $display("FAIL fall_accept: got %b expected 10000100",
                     {bus.btn_level, bus.btn_rise, bus.btn_fall, bus.evt_pending});
        end
        tick(1);
        checks++;
        if ({bus.btn_level, bus.btn_fall, bus.evt_pending} !== 6'b10_00_01) begin
            errors++;
            $display("FAIL fall_evt: got lvl/fall/evt=%b expected 100001",
                     {bus.btn_level, bus.btn_fall, bus.evt_pending});
        end
    endtask

    task automatic test_glitch;
        bus.btn_raw = 2'b00;
        tick(3);
        bus.btn_raw = 2'b10;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            checks++;
            if ({bus.btn_level, bus.btn_rise, bus.btn_fall, bus.evt_pending} !== 8'b10_00_00_01) begin
                errors++;
                $display("FAIL glitch cyc %0d: got %b expected 10000001", i,
                         {bus.btn_level, bus.btn_rise, bus.btn_fall, bus.evt_pending});
            end
        end
    endtask

    task automatic test_bounce;
        int n_fall;
        int n_rise;
        int at;
        logic b;
        n_fall = 0;
        n_rise = 0;
        at     = -1;
        bus.btn_raw = 2'b11;
        tick(8);
        checks++;
        if ({bus.btn_level, bus.evt_pending} !== 4'b11_01) begin
            errors++;
            $display("FAIL bounce_prep: got lvl/evt=%b expected 1101",
                     {bus.btn_level, bus.evt_pending});
        end
        // 0,1,0,1,0,1 in 2-cycle steps, then held 0 from step 12.
        for (int c = 0; c < 25; c++) begin
            b = (c < 12) ? (((c / 2) % 2) == 1) : 1'b0;
            bus.btn_raw = {1'b1, b};
            tick(1);
            if (bus.btn_fall[0]) begin n_fall++; at = c; end
            if (bus.btn_rise[0]) n_rise++;
        end
        checks++;
        if (n_fall !== 1 || n_rise !== 0) begin
            errors++;
            $display("FAIL bounce_count: got falls=%0d rises=%0d expected 1 and 0", n_fall, n_rise);
        end
        checks++;
        if (at !== 17) begin
            errors++;
            $display("FAIL bounce_time: got step %0d expected 17", at);
        end
        checks++;
        if (bus.btn_level !== 2'b10) begin
            errors++;
            $display("FAIL bounce_level: got %b expected 10", bus.btn_level);
        end
    endtask

    task automatic test_set_clr_collision;
        bus.btn_raw = 2'b11;
        tick(5);
        checks++;
        if (bus.btn_rise !== 2'b00) begin
            errors++;
            $display("FAIL coll_early_rise: got %b expected 00", bus.btn_rise);
        end
        tick(1);
        checks++;
        if (bus.btn_rise !== 2'b01) begin
            errors++;
            $display("FAIL coll_rise: got %b expected 01", bus.btn_rise);
        end
        bus.evt_clr = 2'b01;
        tick(1);
        checks++;
        if ({bus.btn_rise, bus.evt_pending} !== 4'b00_01) begin
            errors++;
            $display("FAIL coll_set_wins: got rise/evt=%b expected 0001",
                     {bus.btn_rise, bus.evt_pending});
        end
        bus.evt_clr = 2'b00;
        tick(1);
        checks++;
        if (bus.evt_pending !== 2'b01) begin
            errors++;
            $display("FAIL coll_hold: got %b expected 01", bus.evt_pending);
        end
        bus.evt_clr = 2'b01;
        tick(1);
        bus.evt_clr = 2'b00;
        checks++;
        if (bus.evt_pending !== 2'b00) begin
            errors++;
            $display("FAIL coll_clear: got %b expected 00", bus.evt_pending);
        end
    endtask

    task automatic test_both_channels;
        bus.btn_raw = 2'b00;
        tick(6);
        checks++;
        if ({bus.btn_level, bus.btn_rise, bus.btn_fall} !== 6'b00_00_11) begin
            errors++;
            $display("FAIL both_fall: got lvl/rise/fall=%b expected 000011",
                     {bus.btn_level, bus.btn_rise, bus.btn_fall});
        end
        tick(1);
        checks++;
        if ({bus.btn_fall, bus.evt_pending} !== 4'b00_11) begin
            errors++;
            $display("FAIL both_evt: got fall/evt=%b expected 0011",
                     {bus.btn_fall, bus.evt_pending});
        end
        bus.evt_clr = 2'b11;
        tick(1);
        bus.evt_clr = 2'b00;
        bus.btn_raw = 2'b11;
        tick(6);
        checks++;
        if ({bus.btn_level, bus.btn_rise, bus.btn_fall} !== 6'b11_11_00) begin
            errors++;
            $display("FAIL both_rise: got lvl/rise/fall=%b expected 111100",
                     {bus.btn_level, bus.btn_rise, bus.btn_fall});
        end
        tick(1);
        bus.evt_clr = 2'b11;
        tick(1);
        bus.evt_clr = 2'b00;
        checks++;
        if (bus.evt_pending !== 2'b00) begin
            errors++;
            $display("FAIL both_clear: got %b expected 00", bus.evt_pending);
        end
    endtask

    task automatic test_reset_midcount;
        bus.btn_raw = 2'b10;
        tick(4);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.btn_level, bus.btn_rise, bus.btn_fall, bus.evt_pending} !== 8'b11_00_00_00) begin
            errors++;
            $display("FAIL midreset_async: got %b expected 11000000",
                     {bus.btn_level, bus.btn_rise, bus.btn_fall, bus.evt_pending});
        end
        bus.btn_raw = 2'b11;
        tick(2);
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            checks++;
            if ({bus.btn_level, bus.btn_rise, bus.btn_fall, bus.evt_pending} !== 8'b11_00_00_00) begin
                errors++;
                $display("FAIL midreset_quiet cyc %0d: got %b expected 11000000", i,
                         {bus.btn_level, bus.btn_rise, bus.btn_fall, bus.evt_pending});
            end
        end
    endtask

`ifdef BTN_COND_IRQ_EN
    task automatic test_irq;
        bus.btn_raw = 2'b01;
        tick(8);
        checks++;
        if ({bus.evt_pending, bus.irq} !== 3'b10_0) begin
            errors++;
            $display("FAIL irq_masked: got evt/irq=%b expected 100", {bus.evt_pending, bus.irq});
        end
        bus.btn_raw = 2'b00;
        tick(8);
        checks++;
        if ({bus.evt_pending, bus.irq} !== 3'b11_1) begin
            errors++;
            $display("FAIL irq_set: got evt/irq=%b expected 111", {bus.evt_pending, bus.irq});
        end
        bus.evt_clr = 2'b01;
        tick(2);
        bus.evt_clr = 2'b00;
        checks++;
        if ({bus.evt_pending, bus.irq} !== 3'b10_0) begin
            errors++;
            $display("FAIL irq_clear: got evt/irq=%b expected 100", {bus.evt_pending, bus.irq});
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fall();
        test_glitch();
        test_bounce();
        test_set_clr_collision();
        test_both_channels();
        test_reset_midcount();
`ifdef BTN_COND_IRQ_EN
        test_irq();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
